// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS control FSM with memory-ready handshake and timeout
//
// Steps each instruction through FETCH, DECODE and the execute, memory and writeback states.
// Datapath controls are Moore outputs of the state. The exceptions are FETCH ir_write/pc_write
// and MEM_WR instr_done, which also follow mem_ready_i.
// Optional feature macro: CTRL_JAL_EN adds the jal opcode (000011) and the JAL state.
//
// Ports:
//   clk_i, rst_n_i                 clock (rising edge), asynchronous active-low reset
//   Op_i[5:0]                      opcode from IR[31:26], valid from DECODE onward
//   mem_ready_i                    memory completes the current access this cycle
//   mem_read_o, mem_write_o, iord_o    memory port requests and address select
//   ir_write_o, pc_write_o, pc_write_cond_o, pc_src_o[1:0]    IR/PC update controls
//   alu_src_a_o, alu_src_b_o[1:0], alu_op_o[ALUOP_W-1:0]    ALU operand and operation selects
//   reg_dst_o[1:0], mem2reg_o[1:0], reg_write_o    register file writeback controls
//   instr_done_o                   1-cycle pulse in the final state of each instruction
//   err_o[1:0]                     sticky error: 01 illegal opcode, 10 memory timeout
module multicycle_control #(
    parameter int                 ALUOP_W     = 3,
    parameter logic [ALUOP_W-1:0] ALUOP_ADD   = 3'b000,
    parameter logic [ALUOP_W-1:0] ALUOP_SUB   = 3'b001,
    parameter logic [ALUOP_W-1:0] ALUOP_RTYPE = 3'b111,
    parameter int                 MEM_TIMEOUT = 15
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [5:0]         Op_i,
    input  logic               mem_ready_i,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               iord_o,
    output logic               ir_write_o,
    output logic               pc_write_o,
    output logic               pc_write_cond_o,
    output logic [1:0]         pc_src_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [ALUOP_W-1:0] alu_op_o,
    output logic [1:0]         reg_dst_o,
    output logic [1:0]         mem2reg_o,
    output logic               reg_write_o,
    output logic               instr_done_o,
    output logic [1:0]         err_o
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef CTRL_JAL_EN
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam int         WB_W    = 2;
`else
    localparam int         WB_W    = 1;
`endif

    localparam int                WCNT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WCNT_W-1:0] TIMEOUT_CNT = WCNT_W'(MEM_TIMEOUT);

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
        S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JUMP, S_JAL, S_ERROR
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [1:0]        err_q, err_d;
    // Destination register select latched in DECODE: 0 = rt, 1 = rd, 2 = $31 (jal only).
    logic [WB_W-1:0]   wb_sel_q, wb_sel_d;
    logic              timeout;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            wait_cnt_q <= '0;
            err_q      <= 2'b00;
            wb_sel_q   <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            wb_sel_q   <= wb_sel_d;
        end
    end

    // A ready in the same cycle as the last allowed wait takes priority over the timeout.
    assign timeout = (MEM_TIMEOUT != 0) && (wait_cnt_q == TIMEOUT_CNT) && !mem_ready_i;
    assign err_o   = err_q;

    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = wait_cnt_q;
        err_d           = err_q;
        wb_sel_d        = wb_sel_q;
        mem_read_o      = 1'b0;
        mem_write_o     = 1'b0;
        iord_o          = 1'b0;
        ir_write_o      = 1'b0;
        pc_write_o      = 1'b0;
        pc_write_cond_o = 1'b0;
        pc_src_o        = 2'd0;
        alu_src_a_o     = 1'b0;
        alu_src_b_o     = 2'd0;
        alu_op_o        = '0;
        reg_dst_o       = 2'd0;
        mem2reg_o       = 2'd0;
        reg_write_o     = 1'b0;
        instr_done_o    = 1'b0;

        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                mem_read_o  = 1'b1;
                alu_src_b_o = 2'd1;
                alu_op_o    = ALUOP_ADD;
                ir_write_o  = mem_ready_i;
                pc_write_o  = mem_ready_i;
                if (mem_ready_i) state_d = S_DECODE;
            end
            S_DECODE: begin
                alu_src_b_o = 2'd3;
                alu_op_o    = ALUOP_ADD;
                wb_sel_d    = '0;
                case (Op_i)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_R: begin
                        state_d  = S_EXEC_R;
                        wb_sel_d = WB_W'(1);
                    end
                    OP_ADDI: state_d = S_EXEC_I;
                    OP_BEQ:  state_d = S_BRANCH;
                    OP_J:    state_d = S_JUMP;
`ifdef CTRL_JAL_EN
                    OP_JAL: begin
                        state_d  = S_JAL;
                        wb_sel_d = WB_W'(2);
                    end
`endif
                    default: begin
                        state_d = S_ERROR;
                        err_d   = 2'b01;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_op_o    = ALUOP_ADD;
                state_d     = (Op_i == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read_o = 1'b1;
                iord_o     = 1'b1;
                if (mem_ready_i) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                reg_write_o  = 1'b1;
                mem2reg_o    = 2'd1;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write_o  = 1'b1;
                iord_o       = 1'b1;
                instr_done_o = mem_ready_i;
                if (mem_ready_i) state_d = S_FETCH;
            end
            S_EXEC_R: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = ALUOP_RTYPE;
                state_d     = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'd2;
                alu_op_o    = ALUOP_ADD;
                state_d     = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = 2'(wb_sel_q);
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a_o     = 1'b1;
                alu_op_o        = ALUOP_SUB;
                pc_write_cond_o = 1'b1;
                pc_src_o        = 2'd1;
                instr_done_o    = 1'b1;
                state_d         = S_FETCH;
            end
            S_JUMP: begin
                pc_write_o   = 1'b1;
                pc_src_o     = 2'd2;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
`ifdef CTRL_JAL_EN
            S_JAL: begin
                reg_write_o  = 1'b1;
                reg_dst_o    = 2'(wb_sel_q);
                mem2reg_o    = 2'd2;
                pc_write_o   = 1'b1;
                pc_src_o     = 2'd2;
                instr_done_o = 1'b1;
                state_d      = S_FETCH;
            end
`endif
            S_ERROR: state_d = S_ERROR;
            default: state_d = S_IDLE;
        endcase

        // Wait counting only applies in the three states that wait on the memory.
        if (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR) begin
            if (timeout) begin
                state_d = S_ERROR;
                err_d   = 2'b10;
            end else if (!mem_ready_i) begin
                wait_cnt_d = wait_cnt_q + WCNT_W'(1);
            end
        end
        if (state_d != state_q &&
            (state_d == S_FETCH || state_d == S_MEM_RD || state_d == S_MEM_WR)) begin
            wait_cnt_d = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op;
    logic       ready;
    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond;
    logic [1:0] pc_src, alu_src_b, reg_dst, mem2reg, err;
    logic       alu_src_a, reg_write, instr_done;
    logic [2:0] alu_op;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, RT = 3'b111;
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_JAL = 6'b000011, OP_BAD = 6'b111111;

    multicycle_control dut (
        .clk_i(clk), .rst_n_i(rst_n), .Op_i(op), .mem_ready_i(ready),
        .mem_read_o(mem_read), .mem_write_o(mem_write), .iord_o(iord),
        .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond),
        .pc_src_o(pc_src), .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b),
        .alu_op_o(alu_op), .reg_dst_o(reg_dst), .mem2reg_o(mem2reg),
        .reg_write_o(reg_write), .instr_done_o(instr_done), .err_o(err)
    );

    always #5 clk = ~clk;

    // Observed control word, field order matching ctl() below.
    wire [21:0] obs = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_cond, pc_src,
                       alu_src_a, alu_src_b, alu_op, reg_dst, mem2reg, reg_write, instr_done, err};

    function automatic logic [21:0] ctl(input logic mr, mw, io, irw, pcw, pcwc,
                                        input logic [1:0] pcs, input logic sa,
                                        input logic [1:0] sb, input logic [2:0] aop,
                                        input logic [1:0] rd, m2r, input logic rw, dn,
                                        input logic [1:0] e);
        return {mr, mw, io, irw, pcw, pcwc, pcs, sa, sb, aop, rd, m2r, rw, dn, e};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One cycle: drive inputs, compare the control word mid-cycle, advance past the edge.
    task automatic cyc(input logic rdy, input logic [5:0] opc, input logic [21:0] exp,
                       input string tag);
        ready = rdy;
        op    = opc;
        @(negedge clk);
        check_eq(tag, 32'(obs), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle, then released; leaves the FSM in FETCH.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        ready = 1'b0;
        #1;
        check_eq({tag, "_async"}, 32'(obs), 32'd0);
        @(negedge clk);
        check_eq({tag, "_held"}, 32'(obs), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b0, OP_R, 22'd0, {tag, "_idle"});
    endtask

    logic [21:0] F_WAIT, F_GO, DEC, MADDR, MRD, MWB, MWR0, MWR1, EXR, EXI, WB_RD, WB_RT,
                 BR, JMP, JAL_S, ERR_ILL, ERR_TO;

    initial begin
        F_WAIT  = ctl(1, 0, 0, 0, 0, 0, 2'd0, 0, 2'd1, ADD, 2'd0, 2'd0, 0, 0, 2'b00);
        F_GO    = ctl(1, 0, 0, 1, 1, 0, 2'd0, 0, 2'd1, ADD, 2'd0, 2'd0, 0, 0, 2'b00);
        DEC     = ctl(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd3, ADD, 2'd0, 2'd0, 0, 0, 2'b00);
        MADDR   = ctl(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, ADD, 2'd0, 2'd0, 0, 0, 2'b00);
        MRD     = ctl(1, 0, 1, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 0, 0, 2'b00);
        MWB     = ctl(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 2'd1, 1, 1, 2'b00);
        MWR0    = ctl(0, 1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 0, 0, 2'b00);
        MWR1    = ctl(0, 1, 1, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 0, 1, 2'b00);
        EXR     = ctl(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd0, RT,  2'd0, 2'd0, 0, 0, 2'b00);
        EXI     = ctl(0, 0, 0, 0, 0, 0, 2'd0, 1, 2'd2, ADD, 2'd0, 2'd0, 0, 0, 2'b00);
        WB_RD   = ctl(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 2'd1, 2'd0, 1, 1, 2'b00);
        WB_RT   = ctl(0, 0, 0, 0, 0, 0, 2'd0, 0, 2'd0, 3'd0, 2'd0, 2'd0, 1, 1, 2'b00);
        BR      = ctl(0, 0, 0, 0, 0, 1, 2'd1, 1, 2'd0, SUB, 2'd0, 2'd0, 0, 1, 2'b00);
        JMP     = ctl(0, 0, 0, 0, 1, 0, 2'd2, 0, 2'd0, 3'd0, 2'd0, 2'd0, 0, 1, 2'b00);
        JAL_S   = ctl(0, 0, 0, 0, 1, 0, 2'd2, 0, 2'd0, 3'd0, 2'd2, 2'd2, 1, 1, 2'b00);
        ERR_ILL = 22'd1;
        ERR_TO  = 22'd2;

        rst_n = 1'b0;
        ready = 1'b0;
        op    = OP_R;
        do_reset("por");

        // R-type, ready every cycle: 4 cycles, writeback to rd in the last one.
        cyc(1, OP_R, F_GO, "r_fetch");
        cyc(1, OP_R, DEC,  "r_decode");
        cyc(1, OP_R, EXR,  "r_exec");
        cyc(1, OP_R, WB_RD, "r_wb");

        // addi: writeback to rt, so the latched flag must have been cleared.
        cyc(1, OP_ADDI, F_GO, "addi_fetch");
        cyc(1, OP_ADDI, DEC,  "addi_decode");
        cyc(1, OP_ADDI, EXI,  "addi_exec");
        cyc(1, OP_ADDI, WB_RT, "addi_wb");

        // lw with 3 wait cycles in MEM_RD: 8 cycles, read request held throughout.
        cyc(1, OP_LW, F_GO,  "lw_fetch");
        cyc(1, OP_LW, DEC,   "lw_decode");
        cyc(1, OP_LW, MADDR, "lw_addr");
        for (int i = 0; i < 3; i++) cyc(0, OP_LW, MRD, "lw_rd_wait");
        cyc(1, OP_LW, MRD, "lw_rd_go");
        cyc(1, OP_LW, MWB, "lw_wb");

        // sw with one wait: done only on the ready cycle.
        cyc(1, OP_SW, F_GO,  "sw_fetch");
        cyc(1, OP_SW, DEC,   "sw_decode");
        cyc(1, OP_SW, MADDR, "sw_addr");
        cyc(0, OP_SW, MWR0,  "sw_wr_wait");
        cyc(1, OP_SW, MWR1,  "sw_wr_go");

        cyc(1, OP_BEQ, F_GO, "beq_fetch");
        cyc(1, OP_BEQ, DEC,  "beq_decode");
        cyc(1, OP_BEQ, BR,   "beq_branch");

        // Fetch wait boundary: ready on the 16th wait cycle still wins.
        for (int i = 0; i < 15; i++) cyc(0, OP_J, F_WAIT, "fetch_wait15");
        cyc(1, OP_J, F_GO, "fetch_ready16");
        cyc(1, OP_J, DEC,  "j_decode");
        cyc(1, OP_J, JMP,  "j_jump");

        cyc(1, OP_JAL, F_GO, "jal_fetch");
        cyc(1, OP_JAL, DEC,  "jal_decode");
`ifdef CTRL_JAL_EN
        cyc(1, OP_JAL, JAL_S, "jal_exec");
        cyc(1, OP_R, F_GO, "jal_refetch");
`else
        cyc(1, OP_JAL, ERR_ILL, "jal_illegal");
        do_reset("jal_rst");
        cyc(1, OP_R, F_GO, "jal_refetch");
`endif

        // Reset mid-MEM_RD with ready low: outputs drop at once, FETCH follows release.
        cyc(1, OP_LW, DEC,   "abort_decode");
        cyc(1, OP_LW, MADDR, "abort_addr");
        cyc(0, OP_LW, MRD,   "abort_rd");
        do_reset("abort");
        cyc(0, OP_LW, F_WAIT, "abort_fetch");
        cyc(1, OP_LW, F_GO,   "abort_fetch_go");

        // Illegal opcode: sticky 01 with requests low for 50 cycles, ready toggling.
        cyc(1, OP_BAD, DEC, "ill_decode");
        for (int i = 0; i < 50; i++) cyc(i[0], OP_R, ERR_ILL, "ill_hold");
        do_reset("ill_rst");

        // Fetch timeout: 16 wait cycles then ERROR with err 10.
        for (int i = 0; i < 16; i++) cyc(0, OP_R, F_WAIT, "to_wait");
        cyc(0, OP_R, ERR_TO, "to_error");
        for (int i = 0; i < 4; i++) cyc(1, OP_R, ERR_TO, "to_hold");
        do_reset("to_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
